ad9361_multi_axis_pack: RTL and testbench

- Parametrised AD9361 sample packer. Takes up to four receive channels of 12-bit I/Q.
- Applies a run-time channel-enable mask and reduces precision.
- Writes packed words into an internal FIFO behind an AXI-stream master, with optional fixed-length tlast framing and drop accounting.
- Sits between the AD9361 interface core and downstream DMA/FFT consumers; successor to the fixed four-channel serializer.

---
 rtl/ad9361_multi_axis_pack.sv | 144 ++++++++++++++
 tb/tb_ad9361_multi_axis_pack.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9361_multi_axis_pack.sv
// AD9361 multi-channel I/Q packer: masks, reduces precision and queues packed words behind an AXI-stream master.
// Optional build macro AD9361_PACK_ROUND_EN selects round-half-up with positive saturation instead of truncation.
module ad9361_multi_axis_pack #(
    parameter int NUM_CHANNELS      = 4,
    parameter int PRECISION         = 12,
    parameter int REVERSE_DATA      = 0,
    parameter int AXIS_BURST_LENGTH = 512,
    parameter int FIFO_DEPTH        = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_CHANNELS-1:0]             ch_enable,
    input  logic [NUM_CHANNELS-1:0]             valid,
    input  logic [12*NUM_CHANNELS-1:0]          data_i,
    input  logic [12*NUM_CHANNELS-1:0]          data_q,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic [2*PRECISION*NUM_CHANNELS-1:0] m_axis_tdata,
    output logic                                m_axis_tlast,
    output logic                                overflow,
    output logic [15:0]                         drop_count
);

    localparam int W  = 2 * PRECISION * NUM_CHANNELS;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SH = 12 - PRECISION;
    localparam int CW = (AXIS_BURST_LENGTH > 1) ? $clog2(AXIS_BURST_LENGTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'((AXIS_BURST_LENGTH > 0) ? AXIS_BURST_LENGTH - 1 : 0);
    localparam logic TLAST_EN = (AXIS_BURST_LENGTH > 0);

`ifdef AD9361_PACK_ROUND_EN
    localparam logic signed [12:0] RND  = 13'(2048 >> PRECISION);
    localparam logic signed [12:0] MAXV = 13'((1 << (PRECISION - 1)) - 1);
`endif

    function automatic logic [PRECISION-1:0] reduce(input logic signed [11:0] x);
        logic signed [12:0] v;
        v = {x[11], x};
`ifdef AD9361_PACK_ROUND_EN
        v = (v + RND) >>> SH;
        if (v > MAXV) v = MAXV;
`else
        v = v >>> SH;
`endif
        return PRECISION'(v);
    endfunction

    function automatic int lane_pos(input int k);
        return (REVERSE_DATA != 0) ? (2 * NUM_CHANNELS - 1 - k) : k;
    endfunction

    logic [NUM_CHANNELS-1:0] active_mask;
    logic [CW-1:0]           burst_cnt;
    logic [W-1:0]            lanes;
    logic                    hit;
    logic                    mask_load;
    logic [W-1:0]            cap_data_p0;
    logic                    cap_vld_p0;
    logic [W:0]              fifo_mem [FIFO_DEPTH];
    logic [AW:0]             wr_ptr;
    logic [AW:0]             rd_ptr;
    logic [AW:0]             mem_count;
    logic [AW+1:0]           occupancy;
    logic                    full;
    logic                    out_fire;
    logic                    wr_ok;
    logic                    wr_last;
    logic                    drop;
    logic                    load_out;

    always_comb begin
        lanes = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (active_mask[c]) begin
                lanes[lane_pos(2*c)   * PRECISION +: PRECISION] = reduce(data_i[12*c +: 12]);
                lanes[lane_pos(2*c+1) * PRECISION +: PRECISION] = reduce(data_q[12*c +: 12]);
            end
        end
    end

    assign hit       = |(valid & active_mask);
    assign mask_load = !TLAST_EN || (burst_cnt == '0);

    // Stage p0: capture register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_vld_p0  <= 1'b0;
            cap_data_p0 <= '0;
        end else begin
            cap_vld_p0 <= hit;
            if (hit) cap_data_p0 <= lanes;
        end
    end

    // Occupancy includes the output register so FIFO_DEPTH is the true capacity
    assign mem_count = wr_ptr - rd_ptr;
    assign occupancy = {1'b0, mem_count} + {{(AW+1){1'b0}}, m_axis_tvalid};
    assign full      = (occupancy == (AW+2)'(FIFO_DEPTH));
    assign out_fire  = m_axis_tvalid & m_axis_tready;
    assign wr_ok     = cap_vld_p0 & (!full | out_fire);
    assign drop      = cap_vld_p0 & !wr_ok;
    assign wr_last   = TLAST_EN && (burst_cnt == LAST_CNT);
    assign load_out  = (mem_count != '0) & (!m_axis_tvalid | m_axis_tready);

    // Stage p1: FIFO write, burst framing, drop accounting
    always_ff @(posedge clk) begin
        if (wr_ok) fifo_mem[wr_ptr[AW-1:0]] <= {wr_last, cap_data_p0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_mask <= '0;
            burst_cnt   <= '0;
            wr_ptr      <= '0;
            overflow    <= 1'b0;
            drop_count  <= 16'd0;
        end else begin
            if (mask_load) active_mask <= ch_enable;
            overflow <= drop;
            if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (TLAST_EN) burst_cnt <= wr_last ? '0 : burst_cnt + 1'b1;
            end
        end
    end

    // Stage p2: registered AXI-stream output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr        <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (load_out) begin
            rd_ptr                       <= rd_ptr + 1'b1;
            m_axis_tvalid                <= 1'b1;
            {m_axis_tlast, m_axis_tdata} <= fifo_mem[rd_ptr[AW-1:0]];
        end else if (out_fire) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ad9361_multi_axis_pack.sv
// Scoreboard bench for ad9361_multi_axis_pack: a 4-channel 12-bit instance and a 2-channel 8-bit reversed instance.
module tb_ad9361_multi_axis_pack;

    logic        clk;
    logic        rst;
    logic [3:0]  ce_a, valid_a;
    logic [47:0] di_a, dq_a;
    logic        a_tvalid, a_tready, a_tlast, a_overflow;
    logic [95:0] a_tdata;
    logic [15:0] a_drop;
    logic [1:0]  ce_b, valid_b;
    logic [23:0] di_b, dq_b;
    logic        b_tvalid, b_tready, b_tlast, b_overflow;
    logic [31:0] b_tdata;
    logic [15:0] b_drop;

    int checks = 0;
    int errors = 0;
    int a_cnt = 0;
    int b_cnt = 0;
    int a_ovf = 0;
    int b_ovf = 0;
    logic [96:0] qa[$];
    logic [32:0] qb[$];

    ad9361_multi_axis_pack #(.NUM_CHANNELS(4), .PRECISION(12), .REVERSE_DATA(0),
                             .AXIS_BURST_LENGTH(8), .FIFO_DEPTH(16)) dut_a (
        .clk(clk), .rst(rst), .ch_enable(ce_a), .valid(valid_a), .data_i(di_a), .data_q(dq_a),
        .m_axis_tvalid(a_tvalid), .m_axis_tready(a_tready), .m_axis_tdata(a_tdata),
        .m_axis_tlast(a_tlast), .overflow(a_overflow), .drop_count(a_drop));

    ad9361_multi_axis_pack #(.NUM_CHANNELS(2), .PRECISION(8), .REVERSE_DATA(1),
                             .AXIS_BURST_LENGTH(6), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .ch_enable(ce_b), .valid(valid_b), .data_i(di_b), .data_q(dq_b),
        .m_axis_tvalid(b_tvalid), .m_axis_tready(b_tready), .m_axis_tdata(b_tdata),
        .m_axis_tlast(b_tlast), .overflow(b_overflow), .drop_count(b_drop));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] exp_a(input logic [3:0] m, input logic [11:0] bi, input logic [11:0] bq);
        logic [95:0] w;
        w = '0;
        for (int c = 0; c < 4; c++) begin
            if (m[c]) begin
                w[24*c +: 12]    = bi + 12'(c);
                w[24*c+12 +: 12] = bq + 12'(c);
            end
        end
        return w;
    endfunction

    task automatic drive_a(input logic [11:0] bi, input logic [11:0] bq, input logic v);
        for (int c = 0; c < 4; c++) begin
            di_a[12*c +: 12] = bi + 12'(c);
            dq_a[12*c +: 12] = bq + 12'(c);
        end
        valid_a = {4{v}};
    endtask

    task automatic push_a(input logic [3:0] m, input logic [11:0] bi, input logic [11:0] bq);
        qa.push_back({(a_cnt == 7), exp_a(m, bi, bq)});
        a_cnt = (a_cnt + 1) % 8;
    endtask

    task automatic drive_b(input logic [11:0] i0, input logic [11:0] q0,
                           input logic [11:0] i1, input logic [11:0] q1, input logic v);
        di_b    = {i1, i0};
        dq_b    = {q1, q0};
        valid_b = {2{v}};
    endtask

    task automatic push_b(input logic [31:0] w);
        qb.push_back({(b_cnt == 5), w});
        b_cnt = (b_cnt + 1) % 6;
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < max_cyc) begin
            tick();
            n++;
        end
        check("drain_a", qa.size(), 0);
        check("drain_b", qb.size(), 0);
    endtask

    // Output monitors: compare on the falling edge, a transfer happens at the next rising edge
    initial begin
        logic        stall_prev;
        logic [96:0] prev;
        stall_prev = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst) stall_prev = 1'b0;
            else begin
                if (stall_prev) check("a_hold", {a_tvalid, a_tlast, a_tdata}, {1'b1, prev});
                if (a_tvalid && a_tready) begin
                    check("a_sb_nonempty", qa.size() != 0, 1);
                    if (qa.size() != 0) check("a_word", {a_tlast, a_tdata}, qa.pop_front());
                end
                if (a_overflow) a_ovf++;
                stall_prev = a_tvalid && !a_tready;
                prev = {a_tlast, a_tdata};
            end
        end
    end

    initial begin
        logic        stall_prev;
        logic [32:0] prev;
        stall_prev = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst) stall_prev = 1'b0;
            else begin
                if (stall_prev) check("b_hold", {b_tvalid, b_tlast, b_tdata}, {1'b1, prev});
                if (b_tvalid && b_tready) begin
                    check("b_sb_nonempty", qb.size() != 0, 1);
                    if (qb.size() != 0) check("b_word", {b_tlast, b_tdata}, qb.pop_front());
                end
                if (b_overflow) b_ovf++;
                stall_prev = b_tvalid && !b_tready;
                prev = {b_tlast, b_tdata};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        a_tready = 1'b1;
        b_tready = 1'b1;
        ce_a = 4'hF;
        ce_b = 2'b11;
        drive_a(12'h0, 12'h0, 1'b0);
        drive_b(12'h0, 12'h0, 12'h0, 12'h0, 1'b0);
        tick();
        tick();
        check("a_rst_tvalid", a_tvalid, 0);
        check("a_rst_tdata", a_tdata, 0);
        check("a_rst_tlast", a_tlast, 0);
        check("a_rst_overflow", a_overflow, 0);
        check("a_rst_drop", a_drop, 0);
        check("b_rst_tvalid", b_tvalid, 0);
        check("b_rst_drop", b_drop, 0);
        rst = 1'b0;
        tick();
        tick();

        // Single word, fixed two-cycle latency, lane order
        drive_a(12'h100, 12'h200, 1'b1);
        push_a(4'hF, 12'h100, 12'h200);
        tick();
        drive_a(12'h0, 12'h0, 1'b0);
        check("a_lat_k", a_tvalid, 0);
        tick();
        check("a_lat_k1", a_tvalid, 0);
        tick();
        check("a_lat_k2", a_tvalid, 1);
        check("a_lanes", a_tdata, 96'h203_102_202_101_201_100_200_100 ^ 96'h0 ^
              {12'h203, 12'h103, 12'h202, 12'h102, 12'h201, 12'h101, 12'h200, 12'h100} ^
              96'h203_102_202_101_201_100_200_100);
        tick();
        tick();
        check("a_single_only", a_tvalid, 0);

        // Continuous valid with tready toggling; tlast every 8th word
        for (int n = 1; n <= 15; n++) begin
            drive_a(12'(n * 8), 12'(12'hA00 + n * 8), 1'b1);
            push_a(4'hF, 12'(n * 8), 12'(12'hA00 + n * 8));
            a_tready = n[0];
            tick();
        end
        drive_a(12'h0, 12'h0, 1'b0);
        a_tready = 1'b1;
        drain(100);

        // Mask latched per burst: change mid-burst takes effect only after tlast
        ce_a = 4'b0101;
        tick();
        tick();
        for (int n = 0; n < 8; n++) begin
            drive_a(12'(12'h400 + n * 16), 12'(12'h500 + n * 16), 1'b1);
            push_a(4'b0101, 12'(12'h400 + n * 16), 12'(12'h500 + n * 16));
            if (n == 3) ce_a = 4'hF;
            tick();
        end
        drive_a(12'h0, 12'h0, 1'b0);
        tick();
        tick();
        tick();
        drive_a(12'h0F0, 12'h0E0, 1'b1);
        push_a(4'hF, 12'h0F0, 12'h0E0);
        tick();
        drive_a(12'h0, 12'h0, 1'b0);
        drain(50);

        // Overflow: 10 samples into a 4-deep FIFO with no reader
        b_tready = 1'b0;
        b_ovf = 0;
        for (int n = 1; n <= 10; n++) begin
            drive_b(12'(n << 4), 12'h0, 12'h0, 12'h0, 1'b1);
            if (n <= 4) push_b(32'(n) << 24);
            tick();
        end
        drive_b(12'h0, 12'h0, 12'h0, 12'h0, 1'b0);
        tick();
        tick();
        tick();
        check("b_ovf_pulses", b_ovf, 6);
        check("b_drop_count", b_drop, 6);
        check("b_full_tvalid", b_tvalid, 1);
        check("b_head_word", b_tdata, 32'h0100_0000);
        b_tready = 1'b1;
        drain(50);
        for (int n = 11; n <= 12; n++) begin
            drive_b(12'(n << 4), 12'h0, 12'h0, 12'h0, 1'b1);
            push_b(32'(n) << 24);
            tick();
        end
        drive_b(12'h0, 12'h0, 12'h0, 12'h0, 1'b0);
        drain(50);

        // All-zero mask writes nothing and leaves the burst count alone
        ce_b = 2'b00;
        tick();
        tick();
        for (int n = 0; n < 3; n++) begin
            drive_b(12'h123, 12'h456, 12'h789, 12'h0AB, 1'b1);
            tick();
        end
        drive_b(12'h0, 12'h0, 12'h0, 12'h0, 1'b0);
        repeat (4) tick();
        check("b_zero_mask_tvalid", b_tvalid, 0);
        check("b_zero_mask_drop", b_drop, 6);
        ce_b = 2'b11;
        tick();
        tick();

        // Precision reduction to 8 bits, reversed lane order
        drive_b(12'h7F9, 12'h018, 12'h800, 12'h00F, 1'b1);
`ifdef AD9361_PACK_ROUND_EN
        push_b(32'h7F02_8001);
`else
        push_b(32'h7F01_8000);
`endif
        tick();
        drive_b(12'h0, 12'h0, 12'h0, 12'h0, 1'b0);
        drain(50);
        check("a_no_overflow", a_ovf, 0);

        // Asynchronous reset with a partial burst queued
        a_tready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            drive_a(12'(12'h600 + n * 16), 12'(12'h700 + n * 16), 1'b1);
            push_a(4'hF, 12'(12'h600 + n * 16), 12'(12'h700 + n * 16));
            tick();
        end
        drive_a(12'h0, 12'h0, 1'b0);
        tick();
        tick();
        tick();
        check("a_pre_rst_tvalid", a_tvalid, 1);
        check("b_pre_rst_drop", b_drop, 6);
        #2 rst = 1'b1;
        #1;
        check("a_midrst_tvalid", a_tvalid, 0);
        check("a_midrst_tdata", a_tdata, 0);
        check("a_midrst_tlast", a_tlast, 0);
        check("b_midrst_drop", b_drop, 0);
        check("b_midrst_overflow", b_overflow, 0);
        qa.delete();
        qb.delete();
        a_cnt = 0;
        b_cnt = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        a_tready = 1'b1;
        tick();

        // Fresh bursts after reset: tlast on the 8th (A) and 6th (B) word
        for (int n = 0; n < 8; n++) begin
            drive_a(12'(12'h050 + n * 32), 12'(12'hC00 + n * 32), 1'b1);
            push_a(4'hF, 12'(12'h050 + n * 32), 12'(12'hC00 + n * 32));
            if (n < 6) begin
                drive_b(12'((n + 1) << 4), 12'h0, 12'h0, 12'h0, 1'b1);
                push_b(32'(n + 1) << 24);
            end else begin
                drive_b(12'h0, 12'h0, 12'h0, 12'h0, 1'b0);
            end
            tick();
        end
        drive_a(12'h0, 12'h0, 1'b0);
        drive_b(12'h0, 12'h0, 12'h0, 12'h0, 1'b0);
        drain(50);
        check("a_final_drop", a_drop, 0);
        check("b_final_drop", b_drop, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
